// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax datapath.
// Q8.8 element type, beat geometry and the feeder state encoding.
package softmax_pkg;

    localparam int Q88_W  = 16;
    localparam int LANES  = 4;
    localparam int BEAT_W = Q88_W * LANES;
    localparam int N_DEF  = 64;

    typedef logic signed [Q88_W-1:0] q88_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic q88_t q88_max(input q88_t a, input q88_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/q88_max_tracker.sv
// Running signed maximum over a stream of Q8.8 samples.
// init restarts the max from the incoming sample, never from zero.
module q88_max_tracker
    import softmax_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic update,
    input  q88_t din,
    output q88_t value_next
);

    q88_t value;

    assign value_next = init ? din : q88_max(value, din);

    // latch the new running max on every accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (update) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/softmax_feeder.sv
// Collects N Q8.8 logits, then streams them as 4-lane beats with max_x.
// Holds off the next vector until the result stream reports rx_done.
module softmax_feeder
    import softmax_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = Q88_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    output logic              valid_out,
    output logic [BEAT_W-1:0] out_data,
    output logic [W-1:0]      max_x,
    input  logic              rx_done,
    output logic              busy
);

    localparam int NB = N / LANES;
    localparam int FW = $clog2(N);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NB - 1);

    state_t            state;
    logic [FW-1:0]     fill_cnt;
    logic [BW-1:0]     beat_idx;
    q88_t              buf_q [N];
    logic              accept;
    q88_t              max_next;
    logic [BEAT_W-1:0] beat;

    assign s_ready = en && (state == FILL);
    assign accept  = s_valid && s_ready;

    q88_max_tracker u_max (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (fill_cnt == '0),
        .update     (accept),
        .din        ($signed(s_data)),
        .value_next (max_next)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [FW-1:0] rd_idx;
        assign rd_idx = FW'({beat_idx, 2'b00}) + FW'(k);
        assign beat[k*W +: W] = buf_q[rd_idx];
    end

    // sample buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[fill_cnt] <= $signed(s_data);
        end
    end

    // frame sequencer with registered beat, max and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            beat_idx  <= '0;
            valid_out <= 1'b0;
            out_data  <= '0;
            max_x     <= '0;
            busy      <= 1'b0;
        end else if (!en) begin
            valid_out <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    valid_out <= 1'b0;
                    if (s_valid) begin
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            max_x    <= max_next;
                            state    <= SEND;
                            busy     <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                end
                SEND: begin
                    valid_out <= 1'b1;
                    out_data  <= beat;
                    if (beat_idx == BEAT_LAST) begin
                        beat_idx <= '0;
                        state    <= WAIT;
                    end else begin
                        beat_idx <= beat_idx + BW'(1);
                    end
                end
                WAIT: begin
                    valid_out <= 1'b0;
                    if (rx_done) begin
                        state <= FILL;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    state     <= FILL;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_feeder.sv
// Scoreboard bench for softmax_feeder: directed vectors in,
// expected beats queued at issue time and checked by a monitor.
module tb_softmax_feeder;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        valid_out;
    logic [63:0] out_data;
    logic [15:0] max_x;
    logic        rx_done;
    logic        busy;

    exp_t        sb [$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          beats_seen = 0;
    int          start_cnt;
    logic [15:0] vec [64];
    logic [63:0] last_beat;

    softmax_feeder #(.N(64), .W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .valid_out (valid_out),
        .out_data  (out_data),
        .max_x     (max_x),
        .rx_done   (rx_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic logic [15:0] vmax();
        logic [15:0] m;
        m = vec[0];
        for (int i = 1; i < 64; i++)
            if ($signed(vec[i]) > $signed(m)) m = vec[i];
        return m;
    endfunction

    // monitor: every valid beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            beats_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %h want none", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_data", out_data, mon_e.d);
                chk("beat_max", max_x, mon_e.m);
            end
        end
    end

    // call at posedge+1 with vec loaded; returns at posedge+1 in SEND
    task automatic feed(input bit gaps, input logic [15:0] prev_max);
        int          i;
        int          guard;
        logic [15:0] m;
        exp_t        e;
        m = vmax();
        for (int b = 0; b < 16; b++) begin
            e.d = {vec[4*b+3], vec[4*b+2], vec[4*b+1], vec[4*b]};
            e.m = m;
            sb.push_back(e);
        end
        last_beat = {vec[63], vec[62], vec[61], vec[60]};
        i = 0;
        guard = 0;
        while (i < 64 && guard < 1000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = vec[i];
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (i == 63) chk("max_hold", max_x, prev_max);
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        if (i < 64) timeout("feed");
        chk("max_update", max_x, m);
        chk("ready_send", s_ready, 0);
    endtask

    task automatic wait_beats();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) timeout("beats");
        #1;
    endtask

    task automatic finish_frame();
        @(negedge clk);
        chk("ready_wait", s_ready, 0);
        chk("busy_wait", busy, 1);
        chk("valid_wait", valid_out, 0);
        chk("hold_data", out_data, last_beat);
        @(posedge clk);
        #1 rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        @(negedge clk);
        chk("ready_fill", s_ready, 1);
        chk("busy_fill", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        rx_done = 1'b0;
        #3;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", out_data, 0);
        chk("rst_max", max_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ramp with first-beat latency
        for (int i = 0; i < 64; i++) vec[i] = 16'(i * 256);
        start_cnt = beats_seen;
        feed(1'b0, 16'h0000);
        @(negedge clk);
        chk("lat_edge0", valid_out, 0);
        @(negedge clk);
        chk("lat_edge1", valid_out, 1);
        wait_beats();
        chk("ramp_count", beats_seen - start_cnt, 16);
        finish_frame();

        // max hold plus rx_done ignored during SEND
        for (int i = 0; i < 64; i++) vec[i] = 16'(i);
        vec[50] = 16'h0080;
        feed(1'b0, 16'h3F00);
        repeat (3) @(posedge clk);
        #1 rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        wait_beats();
        repeat (3) @(posedge clk);
        #1;
        finish_frame();

        // all negative
        for (int i = 0; i < 64; i++) vec[i] = 16'hFF00;
        vec[37] = 16'hFE80;
        feed(1'b0, 16'h0080);
        wait_beats();
        finish_frame();

        // gaps in FILL, stall after beat 5
        for (int i = 0; i < 64; i++) vec[i] = 16'(i * 256);
        start_cnt = beats_seen;
        feed(1'b1, 16'hFF00);
        repeat (6) @(posedge clk);
        #1 en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", valid_out, 0);
        end
        en = 1'b1;
        wait_beats();
        chk("stall_count", beats_seen - start_cnt, 16);
        finish_frame();

        // reset at beat 7, then a fresh vector
        feed(1'b0, 16'h3F00);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_max", max_x, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 64; i++) vec[i] = 16'(i * 3 - 100);
        start_cnt = beats_seen;
        feed(1'b0, 16'h0000);
        wait_beats();
        chk("fresh_count", beats_seen - start_cnt, 16);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
